// File: rtl/arb_mux.sv
// ---------------------------------------------------------------------------
// arb_mux
//   Arbitrates among CHANNELS valid/ready input channels and forwards the
//   selected word through a single output register stage.
//
//   Default build: round-robin arbitration. The search starts one past the
//   last granted channel and wraps around.
//   Build with ARB_MUX_FIXED_PRIO_EN defined: fixed priority, where the
//   lowest valid index wins and no last-grant state exists.
//
// Parameters:
//   WIDTH     - bit width of each data word
//   CHANNELS  - number of input channels (2..16)
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high reset
//   in_valid   - per-channel word-available flags
//   in_data    - channel i word at bits [i*WIDTH +: WIDTH]
//   in_ready   - one-hot accept strobe for the granted channel (or zero)
//   out_valid  - output register holds a word
//   out_data   - registered selected word
//   out_chan   - source channel index of out_data
//   out_ready  - downstream accepts the word when out_valid is also high
// ---------------------------------------------------------------------------
module arb_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           in_valid,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic [CHANNELS-1:0]           in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(CHANNELS)-1:0]   out_chan,
  input  logic                          out_ready
);

  localparam int CW = $clog2(CHANNELS);

  logic          can_load;
  logic          grant_any;
  logic [CW-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic          load;

  // The register can take a new word when it is empty or being drained
  // in this same cycle, which gives one word per cycle with no bubble.
  assign can_load = !out_valid || out_ready;

`ifdef ARB_MUX_FIXED_PRIO_EN

  // Fixed priority: scan from the top down so that the lowest valid index
  // is the last one written and therefore wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = CW'(i);
      end
    end
  end

`else

  logic [CW-1:0] last_grant;
  logic          hi_any;
  logic [CW-1:0] hi_idx;
  logic [CW-1:0] lo_idx;

  // Round-robin without a modulo: find the lowest valid index above
  // last_grant; if there is none, the search wraps around and the lowest
  // valid index overall wins.
  always_comb begin
    grant_any = 1'b0;
    hi_any    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        grant_any = 1'b1;
        lo_idx    = CW'(i);
        if (CW'(i) > last_grant) begin
          hi_any = 1'b1;
          hi_idx = CW'(i);
        end
      end
    end
    grant_idx = hi_any ? hi_idx : lo_idx;
  end

  // last_grant only moves on a completed input transfer. Reset points it at
  // the top channel, so channel 0 is searched first afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= CW'(CHANNELS - 1);
    end else if (load) begin
      last_grant <= grant_idx;
    end
  end

`endif

  // in_ready is built from the grant only and never looks at in_data.
  // Reset forces it low, so nothing is accepted during a reset cycle.
  assign in_ready = (!reset && can_load && grant_any)
                    ? (CHANNELS'(1) << grant_idx) : '0;

  assign load = !reset && can_load && grant_any;

  // Data path mux for the granted channel; this feeds only the register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == CW'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register. A load has priority over a drain. On a drain with no
  // new word, out_valid drops but data and channel keep their last values.
  // Reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
